// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU. Single-cycle logic/arith/shift ops,
// plus iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor
    logic [1:0]         iop_q, iop_d;       // f[1:0] of the iterative op in flight
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   simple_res;
    logic               simple_err;
    logic [SHW-1:0]     sh_amt;

    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   iter_res;

    assign sh_amt = b[SHW-1:0];

    // Single-cycle result from the live request operands
    always_comb begin
        simple_res = '0;
        simple_err = 1'b0;
        case (f)
            4'b0000: simple_res = a & b;
            4'b0001: simple_res = a | b;
            4'b0010: simple_res = a + b;
            4'b0100: simple_res = a & ~b;
            4'b0101: simple_res = a | ~b;
            4'b0110: simple_res = a - b;
            4'b0111: simple_res = WIDTH'(a < b);
            4'b1000: simple_res = a << sh_amt;
            4'b1001: simple_res = a >> sh_amt;
            4'b1010: simple_res = WIDTH'($signed(a) >>> sh_amt);
            default: simple_err = 1'b1;
        endcase
    end

    // One multiply or divide iteration on the accumulator
    always_comb begin
        hi        = acc_q[2*WIDTH-1:WIDTH];
        lo        = acc_q[WIDTH-1:0];
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
        div_sh    = {hi, lo[WIDTH-1]};
        div_ge    = (div_sh >= {1'b0, opnd_q});
        div_diff  = WIDTH'(div_sh - {1'b0, opnd_q});
        rem_next  = div_ge ? div_diff : div_sh[WIDTH-1:0];
        step_next = iop_q[1] ? {rem_next, lo[WIDTH-2:0], div_ge}
                             : {mul_sum, lo[WIDTH-1:1]};
        // MUL/DIVU take the low half, MULHU/REMU the high half
        iter_res  = iop_q[0] ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        iop_d   = iop_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (f[3:2] == 2'b11) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        iop_d   = f[1:0];
                        if (f[1]) begin
                            acc_d  = {{WIDTH{1'b0}}, a};
                            opnd_d = b;
                        end else begin
                            acc_d  = {{WIDTH{1'b0}}, b};
                            opnd_d = a;
                        end
                    end else begin
                        state_d = DONE;
                        y_d     = simple_res;
                        zero_d  = (simple_res == '0);
                        err_d   = simple_err;
                    end
                end
            end
            BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    y_d     = iter_res;
                    zero_d  = (iter_res == '0);
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            opnd_q      <= '0;
            iop_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            iop_q       <= iop_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed and random ops against an arithmetic reference model,
// on a 32-bit and an 8-bit instance.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        iv32, ir32, ov32, or32, z32, e32;
    logic [31:0] a32, b32, y32;
    logic [3:0]  f32;
    logic        iv8, ir8, ov8, or8, z8, e8;
    logic [7:0]  a8, b8, y8;
    logic [3:0]  f8;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .f(f32), .out_valid(ov32), .out_ready(or32),
        .y(y32), .zero(z32), .err(e32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .f(f8), .out_valid(ov8), .out_ready(or8),
        .y(y8), .zero(z8), .err(e8)
    );

    // Reference: plain arithmetic on 64-bit values, truncated to w bits
    function automatic longint unsigned ref_y(int w, logic [3:0] f,
                                              longint unsigned a, longint unsigned b);
        longint unsigned mask, r;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        sh   = int'(b % longint'(w));
        case (f)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd4:    r = a & ~b;
            4'd5:    r = a | ~b;
            4'd6:    r = a - b;
            4'd7:    r = (a < b) ? 64'd1 : 64'd0;
            4'd8:    r = a << sh;
            4'd9:    r = a >> sh;
            4'd10:   r = (a >> sh) | (((a >> (w - 1)) & 64'd1) != 0 ? (mask & ~(mask >> sh)) : 64'd0);
            4'd12:   r = a * b;
            4'd13:   r = (a * b) >> w;
            4'd14:   r = (b == 0) ? mask : a / b;
            4'd15:   r = (b == 0) ? a : a % b;
            default: r = 64'd0;
        endcase
        return r & mask;
    endfunction

    function automatic logic ref_err(logic [3:0] f);
        return (f == 4'd3) || (f == 4'd11);
    endfunction

    function automatic int ref_lat(int w, logic [3:0] f);
        return (f[3:2] == 2'b11) ? w + 1 : 1;
    endfunction

    // Issue one op on the 32-bit instance, wait for the result, then consume it
    task automatic do_op32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] y, output logic z, output logic e,
                           output int lat, output int rdy_hi,
                           output logic ov_after, output logic rdy_after);
        rdy_hi = 0;
        f32 = f; a32 = a; b32 = b; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 1;
        while (ov32 !== 1'b1 && lat < 200) begin
            if (ir32 !== 1'b0) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        y = y32; z = z32; e = e32;
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        ov_after = ov32; rdy_after = ir32;
    endtask

    task automatic do_op8(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] y, output logic z, output logic e, output int lat);
        f8 = f; a8 = a; b8 = b; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 1;
        while (ov8 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        y = y8; z = z8; e = e8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    // Check one completed 32-bit op against the model
    task automatic run_check32(input string tag, input logic [3:0] f,
                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y, ey;
        logic z, e, ova, rda;
        int lat, rh, elat;
        do_op32(f, a, b, y, z, e, lat, rh, ova, rda);
        ey   = 32'(ref_y(32, f, {32'd0, a}, {32'd0, b}));
        elat = ref_lat(32, f);
        total++; if (y !== ey) begin bad++; $display("FAIL %s y f=%0h a=%h b=%h: got %h want %h", tag, f, a, b, y, ey); end
        total++; if (z !== (ey == 0)) begin bad++; $display("FAIL %s zero f=%0h: got %b want %b", tag, f, z, ey == 0); end
        total++; if (e !== ref_err(f)) begin bad++; $display("FAIL %s err f=%0h: got %b want %b", tag, f, e, ref_err(f)); end
        total++; if (lat != elat) begin bad++; $display("FAIL %s latency f=%0h: got %0d want %0d", tag, f, lat, elat); end
        total++; if (rh != 0) begin bad++; $display("FAIL %s in_ready high while busy: got %0d cycles want 0", tag, rh); end
        total++; if (ova !== 1'b0 || rda !== 1'b1) begin bad++; $display("FAIL %s release: got ov=%b rdy=%b want 0 1", tag, ova, rda); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        total++; if (ir32 !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", ir32); end
        total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", ov32); end
        total++; if (y32 !== 32'd0) begin bad++; $display("FAIL reset y: got %h want 0", y32); end
        total++; if (z32 !== 1'b0 || e32 !== 1'b0) begin bad++; $display("FAIL reset zero/err: got %b %b want 0 0", z32, e32); end
        total++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin bad++; $display("FAIL reset w8: got rdy=%b ov=%b want 1 0", ir8, ov8); end
    endtask

    task automatic test_simple();
        logic [3:0] f;
        logic [31:0] a, b;
        run_check32("simple_sub0", 4'b0110, 32'd5, 32'd5);
        run_check32("simple_slt", 4'b0111, 32'd1, 32'hFFFF_FFFF);
        run_check32("simple_sra", 4'b1010, 32'h8000_0000, 32'd36);
        run_check32("simple_ill3", 4'b0011, 32'h1234, 32'h5678);
        run_check32("simple_ill11", 4'b1011, 32'hFFFF, 32'h1);
        for (int i = 0; i < 40; i++) begin
            f = 4'($urandom_range(0, 11));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            run_check32("simple_rand", f, a, b);
        end
    endtask

    task automatic test_mul();
        logic [31:0] a, b;
        run_check32("mul_lo", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_check32("mul_hi", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            run_check32("mul_rand", 4'(12 + (i % 2)), a, b);
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        run_check32("divu", 4'b1110, 32'd100, 32'd7);
        run_check32("remu", 4'b1111, 32'd100, 32'd7);
        run_check32("divu_by0", 4'b1110, 32'd100, 32'd0);
        run_check32("remu_by0", 4'b1111, 32'd123, 32'd0);
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom >> $urandom_range(0, 31);
            if (i == 5) b = 32'd0;
            run_check32("div_rand", 4'(14 + (i % 2)), a, b);
        end
    endtask

    task automatic test_backpressure();
        f32 = 4'b0010; a32 = 32'd3; b32 = 32'd4; iv32 = 1'b1; or32 = 1'b0;
        @(posedge clk); #1;
        iv32 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (ov32 !== 1'b1 || y32 !== 32'd7 || ir32 !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc%0d: got ov=%b y=%h rdy=%b want 1 7 0", i, ov32, y32, ir32);
            end
            f32 = 4'b0110; a32 = $urandom; b32 = $urandom; iv32 = i[0];
            @(posedge clk); #1;
        end
        iv32 = 1'b0;
        total++; if (ov32 !== 1'b1 || y32 !== 32'd7) begin bad++; $display("FAIL bp_end: got ov=%b y=%h want 1 7", ov32, y32); end
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        total++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin bad++; $display("FAIL bp_release: got ov=%b rdy=%b want 0 1", ov32, ir32); end
    endtask

    task automatic test_reset_mid();
        int seen;
        f32 = 4'b1110; a32 = 32'd1000; b32 = 32'd3; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (ir32 !== 1'b1 || ov32 !== 1'b0) begin bad++; $display("FAIL rstmid state: got rdy=%b ov=%b want 1 0", ir32, ov32); end
        total++; if (y32 !== 32'd0) begin bad++; $display("FAIL rstmid y: got %h want 0", y32); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov32 !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid orphan result: got %0d valid cycles want 0", seen); end
        run_check32("rstmid_add", 4'b0010, 32'd1, 32'd1);
    endtask

    task automatic test_back_to_back();
        int n;
        f32 = 4'b0010; a32 = 32'd3; b32 = 32'd4; iv32 = 1'b1; or32 = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ov32 === 1'b1) begin
                n++;
                total++; if (y32 !== 32'd7) begin bad++; $display("FAIL b2b y: got %h want 7", y32); end
            end
        end
        iv32 = 1'b0; or32 = 1'b0;
        total++; if (n != 5) begin bad++; $display("FAIL b2b count: got %0d want 5", n); end
        @(posedge clk); #1;
        total++; if (ir32 !== 1'b1 || ov32 !== 1'b0) begin bad++; $display("FAIL b2b idle: got rdy=%b ov=%b want 1 0", ir32, ov32); end
    endtask

    task automatic test_width8();
        logic [7:0] y, ey, a, b;
        logic [3:0] f;
        logic z, e;
        int lat;
        do_op8(4'b1100, 8'h10, 8'h10, y, z, e, lat);
        total++; if (y !== 8'h00 || z !== 1'b1) begin bad++; $display("FAIL w8_mul: got y=%h z=%b want 00 1", y, z); end
        total++; if (lat != 9) begin bad++; $display("FAIL w8_mul latency: got %0d want 9", lat); end
        for (int i = 0; i < 30; i++) begin
            f = 4'($urandom_range(0, 15));
            a = 8'($urandom); b = 8'($urandom);
            if (i % 7 == 0) b = 8'd0;
            do_op8(f, a, b, y, z, e, lat);
            ey = 8'(ref_y(8, f, {56'd0, a}, {56'd0, b}));
            total++; if (y !== ey || z !== (ey == 0) || e !== ref_err(f)) begin
                bad++; $display("FAIL w8_rand f=%0h a=%h b=%h: got y=%h z=%b e=%b want %h %b %b", f, a, b, y, z, e, ey, ey == 0, ref_err(f));
            end
            total++; if (lat != ref_lat(8, f)) begin bad++; $display("FAIL w8_rand latency f=%0h: got %0d want %0d", f, lat, ref_lat(8, f)); end
        end
    endtask

    initial begin
        reset = 1'b1;
        iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; f32 = '0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; f8 = '0;
        test_reset();
        test_simple();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
